// File: rtl/display_pkg.sv
// Shared display definitions: arbiter FSM states and display word width.
package display_pkg;
    localparam int DISP_W = 32;

    typedef enum logic {
        DS_IDLE,
        DS_SHOW
    } ds_state_t;
endpackage

// File: rtl/rr_next_pick.sv
// Circular upward search for the next set request bit starting at a given index.
module rr_next_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          excl,
    output logic          found,
    output logic [IW-1:0] next
);
    logic [IW-1:0] cand;

    // Walk offsets from far to near so the closest hit overwrites earlier ones.
    always_comb begin
        found = 1'b0;
        next  = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (k != 0 || !excl) begin
                cand = IW'((int'(start) + k) % N);
                if (req[cand]) begin
                    found = 1'b1;
                    next  = cand;
                end
            end
        end
    end
endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin, dwell-timed time-sharing of the seven-segment display value among requesters.
module display_share_arbiter
    import display_pkg::*;
#(
    parameter int                NUM_REQ      = 4,
    parameter int                DWELL_CYCLES = 100_000_000,
    parameter logic [DISP_W-1:0] IDLE_VAL     = 32'h0000_0000,
    localparam int               IW           = $clog2(NUM_REQ),
    localparam int               CW           = $clog2(DWELL_CYCLES)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [DISP_W*NUM_REQ-1:0] vals_in,
    output logic [DISP_W-1:0]         val_out,
    output logic [NUM_REQ-1:0]        grant_out,
    output logic [IW-1:0]             owner_out,
    output logic                      swap_out
);
    ds_state_t           state, state_n;
    logic [IW-1:0]       owner, owner_n, ptr, ptr_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                swap_n;
    logic [DISP_W-1:0]   val_n;
    logic [NUM_REQ-1:0]  grant_n;

    logic [IW-1:0]       pick_start, pick_idx;
    logic                pick_excl, pick_found;

    // One search serves both states: from pointer+1 inclusive when idle,
    // strictly after the owner while showing.
    always_comb begin
        if (state == DS_IDLE) begin
            pick_start = (ptr == IW'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;
            pick_excl  = 1'b0;
        end else begin
            pick_start = owner;
            pick_excl  = 1'b1;
        end
    end

    rr_next_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_in),
        .start (pick_start),
        .excl  (pick_excl),
        .found (pick_found),
        .next  (pick_idx)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        swap_n  = 1'b0;
        case (state)
            DS_IDLE: begin
                if (pick_found) begin
                    state_n = DS_SHOW;
                    owner_n = pick_idx;
                    ptr_n   = pick_idx;
                    cnt_n   = '0;
                    swap_n  = 1'b1;
                end
            end
            DS_SHOW: begin
                if (!req_in[owner]) begin
                    cnt_n  = '0;
                    swap_n = 1'b1;
                    if (pick_found) begin
                        owner_n = pick_idx;
                        ptr_n   = pick_idx;
                    end else begin
                        state_n = DS_IDLE;
                        owner_n = '0;
                    end
                end else if (cnt == CW'(DWELL_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (pick_found) begin
                        owner_n = pick_idx;
                        ptr_n   = pick_idx;
                        swap_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = DS_IDLE;
        endcase

        // Outputs are derived from the next owner so all three update on one edge.
        if (state_n == DS_SHOW) begin
            val_n   = vals_in[DISP_W*owner_n +: DISP_W];
            grant_n = NUM_REQ'(1) << owner_n;
        end else begin
            val_n   = IDLE_VAL;
            grant_n = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= DS_IDLE;
            owner     <= '0;
            ptr       <= IW'(NUM_REQ - 1);
            cnt       <= '0;
            val_out   <= IDLE_VAL;
            grant_out <= '0;
            swap_out  <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            val_out   <= val_n;
            grant_out <= grant_n;
            swap_out  <= swap_n;
        end
    end

    assign owner_out = owner;
endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with a short dwell of 8 cycles.
module tb_display_share_arbiter;
    localparam int          NUM_REQ  = 4;
    localparam int          DWELL    = 8;
    localparam logic [31:0] IDLE_VAL = 32'hDEAD_0000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req = '0;
    logic [32*NUM_REQ-1:0]   vals;
    logic [31:0]             val;
    logic [NUM_REQ-1:0]      grant;
    logic [1:0]              owner;
    logic                    swap;

    int n_tests = 0;
    int n_fail  = 0;

    display_share_arbiter #(
        .NUM_REQ(NUM_REQ), .DWELL_CYCLES(DWELL), .IDLE_VAL(IDLE_VAL)
    ) dut (
        .clk_in(clk), .rst_in(rst), .req_in(req), .vals_in(vals),
        .val_out(val), .grant_out(grant), .owner_out(owner), .swap_out(swap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vals();
        for (int i = 0; i < NUM_REQ; i++) vals[32*i +: 32] = 32'h1111_1111 * (i + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        load_vals();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (val !== IDLE_VAL || grant !== 4'b0000 || owner !== 2'd0 || swap !== 1'b0) begin
                n_fail++;
                $display("FAIL reset c%0d: val=%h grant=%b owner=%0d swap=%b want DEAD0000/0000/0/0",
                         c, val, grant, owner, swap);
            end
            step();
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        n_tests++;
        if (grant !== 4'b0100 || owner !== 2'd2 || val !== 32'h3333_3333 || swap !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: val=%h grant=%b owner=%0d swap=%b want 33333333/0100/2/1",
                     val, grant, owner, swap);
        end
        for (int c = 1; c < 20; c++) begin
            step();
            n_tests++;
            if (grant !== 4'b0100 || owner !== 2'd2 || swap !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hold c%0d: grant=%b owner=%0d swap=%b want 0100/2/0",
                         c, grant, owner, swap);
            end
        end
        req = '0;
        step();
        n_tests++;
        if (grant !== 4'b0000 || val !== IDLE_VAL || swap !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release: val=%h grant=%b swap=%b want DEAD0000/0000/1", val, grant, swap);
        end
        step();
        n_tests++;
        if (swap !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_swap: swap=%b want 0", swap);
        end
    endtask

    task automatic test_rotate();
        logic [1:0]  seq [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
        logic [31:0] sv  [4] = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444, 32'h1111_1111};
        do_reset();
        req = 4'b1011;
        step();
        for (int i = 0; i < 4 * DWELL; i++) begin
            n_tests++;
            if (owner !== seq[i/DWELL] || val !== sv[i/DWELL] ||
                grant !== (4'b0001 << seq[i/DWELL]) || swap !== (i % DWELL == 0)) begin
                n_fail++;
                $display("FAIL rotate c%0d: owner=%0d val=%h grant=%b swap=%b want owner %0d val %h swap %b",
                         i, owner, val, grant, swap, seq[i/DWELL], sv[i/DWELL], (i % DWELL == 0));
            end
            step();
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b1010;
        step();
        n_tests++;
        if (owner !== 2'd1 || swap !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_first: owner=%0d swap=%b want 1/1", owner, swap);
        end
        step();
        step();
        // Third cycle of owner 1: drop it, while 0 starts requesting too.
        req = 4'b1001;
        step();
        for (int j = 0; j <= DWELL; j++) begin
            n_tests++;
            if (owner !== ((j < DWELL) ? 2'd3 : 2'd0) || swap !== (j == 0 || j == DWELL)) begin
                n_fail++;
                $display("FAIL drop c%0d: owner=%0d swap=%b want owner %0d swap %b",
                         j, owner, swap, (j < DWELL) ? 3 : 0, (j == 0 || j == DWELL));
            end
            step();
        end
    endtask

    task automatic test_drop_at_expiry();
        do_reset();
        req = 4'b0001;
        step();
        for (int c = 0; c < DWELL - 1; c++) step();
        n_tests++;
        if (owner !== 2'd0 || grant !== 4'b0001 || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_hold: owner=%0d grant=%b swap=%b want 0/0001/0", owner, grant, swap);
        end
        req = '0;
        step();
        n_tests++;
        if (grant !== 4'b0000 || owner !== 2'd0 || val !== IDLE_VAL || swap !== 1'b1) begin
            n_fail++;
            $display("FAIL expiry_drop: val=%h grant=%b owner=%0d swap=%b want DEAD0000/0000/0/1",
                     val, grant, owner, swap);
        end
    endtask

    task automatic test_value_and_reset();
        do_reset();
        req = 4'b0001;
        step();
        step();
        step();
        vals[31:0] = 32'h0000_BEEF;
        #1;
        n_tests++;
        if (val !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL value_pre: val=%h want 11111111", val);
        end
        step();
        n_tests++;
        if (val !== 32'h0000_BEEF || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL value_track: val=%h swap=%b want 0000BEEF/0", val, swap);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (val !== IDLE_VAL || grant !== 4'b0000 || owner !== 2'd0 || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: val=%h grant=%b owner=%0d swap=%b want DEAD0000/0000/0/0",
                     val, grant, owner, swap);
        end
        rst = 1'b0;
        req = 4'b1000;
        step();
        n_tests++;
        if (owner !== 2'd3 || grant !== 4'b1000 || val !== 32'h4444_4444 || swap !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: val=%h grant=%b owner=%0d swap=%b want 44444444/1000/3/1",
                     val, grant, owner, swap);
        end
    endtask

    initial begin
        load_vals();
        test_reset();
        test_single();
        test_rotate();
        test_drop();
        test_drop_at_expiry();
        test_value_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/display_share_arbiter.md
# display_share_arbiter

Time-shares the 8-digit seven-segment display among up to `NUM_REQ` requesters (debug counters, FSM state words, sensor readouts). Sits directly upstream of `seven_segment_controller`: its registered `val_out` drives that block's `val_in`. Arbitration is round-robin with a fixed dwell time per owner, so each active source is shown for a readable interval before the display rotates.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DWELL_CYCLES`, 100_000_000: cycles each owner holds the display when others are waiting, ≥2.
- `IDLE_VAL`, 32'h0000_0000: value driven when no requester is active.

- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  reset; synchronous, active-high.
- `req_in`  in  NUM_REQ  per-requester display request; level-sensitive.
- `vals_in`  in  32*NUM_REQ  packed values; requester i occupies `[32*i+31:32*i]`.
- `val_out`  out  32  value to the display controller; registered.
- `grant_out`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `owner_out`  out  $clog2(NUM_REQ)  index of current owner; 0 when idle.
- `swap_out`  out  1  one-cycle pulse on every cycle where ownership changed (including idle↔owned).

## Operation
- States: IDLE, SHOW.
- Reset: state IDLE; `val_out`=IDLE_VAL; `grant_out`=0; `owner_out`=0; `swap_out`=0; dwell counter=0; round-robin pointer=NUM_REQ-1, so that requester 0 wins first.
- IDLE: if any `req_in` bit is set, pick the first set bit searching upward from pointer+1, with modulo wrap. Then go to SHOW with that owner, counter=0, and pulse `swap_out`. Otherwise stay in IDLE.
- SHOW, each cycle, evaluated in priority order:
  1. Owner's `req_in` low: pick the next active requester after the owner. If one exists, switch to it; else go to IDLE. Counter=0 and pulse `swap_out` in both cases.
  2. Counter == DWELL_CYCLES-1 and another requester is active: switch to the next active requester after the owner, counter=0, pulse `swap_out`.
  3. Counter == DWELL_CYCLES-1 and only the owner is active: keep the owner, counter=0, no pulse.
  4. Otherwise, counter increments.
- Pointer: updated to the new owner on every grant.
- Value tracking: `val_out` follows the live `vals_in` slice of the owner, registered. Owner value changes during SHOW appear one cycle later.
- Simultaneous events:
  - Owner drop and dwell expiry in the same cycle: treated as a drop (rule 1).
  - New requests arriving mid-dwell never preempt the owner.
- `rst_in` mid-SHOW: returns to the reset values on the next edge regardless of `req_in`.

## Timing
- Request-to-display latency from IDLE: `req_in` sampled high at edge t gives `grant_out`, `owner_out`, `val_out` and `swap_out` updated after edge t, i.e. valid in cycle t+1.
- An uncontested owner with other requesters waiting holds exactly DWELL_CYCLES cycles of `grant_out`.
- `grant_out`, `owner_out` and `val_out` always change on the same edge; they are never mutually inconsistent.
- `swap_out` is high for exactly one cycle per change.
- Counter width is $clog2(DWELL_CYCLES). The counter never exceeds DWELL_CYCLES-1 and wraps to 0 as specified above.
- No combinational path from inputs to outputs.

## Structure
- Shared package `display_pkg`: state enum (`DS_IDLE`, `DS_SHOW`) and a `DISP_W = 32` constant, reused by `seven_segment_controller` wrappers.
- Sub-module `rr_next_pick`: purely combinational. Inputs are the request vector, a start index and an exclude-start flag. Outputs are a found flag and the next index, searching circularly upward.
- Top contains the FSM, dwell counter, pointer and output registers.

## Test plan
Run with `NUM_REQ=4`, `DWELL_CYCLES=8`, `IDLE_VAL=32'hDEAD_0000`, `vals_in` slot i = `32'h1111_1111*(i+1)`.
- Reset, no requests → `val_out`=DEAD0000, `grant_out`=0000, `swap_out` never pulses.
- `req_in`=0100 from cycle 5 → cycle 6: `grant_out`=0100, `owner_out`=2, `val_out`=33333333, one `swap_out` pulse; ownership holds indefinitely with no further pulses.
- `req_in`=1011 constant → owners rotate 0→1→3→0, each shown for exactly 8 cycles, `swap_out` pulse at each change.
- Owner 1 drops `req_in` on its 3rd cycle while 3 is requesting → next cycle `owner_out`=3, counter restarts, and 3 gets a full 8 cycles.
- Owner drops on the same cycle its counter hits 7 with no other requesters → IDLE, `val_out`=DEAD0000, `swap_out` pulses.
- Owner 0 changes its value to 0000_BEEF mid-dwell → `val_out`=0000BEEF one cycle later. Then assert `rst_in` mid-SHOW → next cycle all outputs are at reset values; after release with `req_in`=1000, owner 3 is granted.
